mem_master: RTL and testbench

- Initiator-side sequencer for the 16-bit synchronous memory block. It turns single CPU-side read/write requests into the memory's enable/read_write/output_en pin sequence.
- Read sequencing accounts for the memory's registered read data (mdr): read data is valid on the memory output one cycle after the read edge.
- Returns write acknowledgements and read data to the requester over a valid/ready request channel and a one-cycle response pulse.
- Sits between the CPU datapath (MAR/MDR logic) and the memory block.

---
 rtl/mem_master.sv | 126 ++++++++++++
 tb/tb_mem_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// rtl/mem_master.sv - request sequencer for the 16-bit synchronous memory (optional MEM_MASTER_WRITE_VERIFY_EN)
module mem_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read_write,
  output logic                  mem_enable,
  output logic                  mem_output_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  verify_err,
  input  logic                  clear_err
);

  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RESP} state_t;

  state_t                state, state_next;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  accept;

  assign accept    = req_valid && (state == IDLE);
  assign rsp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // Memory output is only guaranteed valid here, one cycle after the read edge
      if (state == RD_DATA)
        rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    state_next     = state;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_write      = 1'b0;
    mem_address    = '0;
    mem_read_write = 1'b0;
    mem_enable     = 1'b0;
    mem_output_en  = 1'b0;
    mem_wdata      = '0;
    if (state != IDLE)
      mem_address = addr_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_next = req_write ? WR : RD_ADDR;
      end
      WR: begin
        mem_enable = 1'b1;
        mem_wdata  = wdata_q;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
        state_next = RD_ADDR;
`else
        state_next = RESP;
`endif
      end
      RD_ADDR: begin
        mem_enable     = 1'b1;
        mem_read_write = 1'b1;
        mem_output_en  = 1'b1;
        state_next     = RD_DATA;
      end
      RD_DATA: begin
        mem_enable     = 1'b1;
        mem_read_write = 1'b1;
        mem_output_en  = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_write  = write_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MEM_MASTER_WRITE_VERIFY_EN
  logic err_q;

  // A mismatch on the same edge as clear_err keeps the flag set
  always_ff @(posedge clk) begin
    if (!reset)
      err_q <= 1'b0;
    else if ((state == RD_DATA) && write_q && (mem_rdata != wdata_q))
      err_q <= 1'b1;
    else if (clear_err)
      err_q <= 1'b0;
  end

  assign verify_err = err_q;
`else
  logic unused_clear_err;
  assign unused_clear_err = clear_err;
  assign verify_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - directed vector bench for mem_master with a registered-read memory model
module tb_mem_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_write;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_address;
  logic        mem_read_write;
  logic        mem_enable;
  logic        mem_output_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        verify_err;
  logic        clear_err = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] last_rdata = '0;
  logic        bad_read = 1'b0;

  logic [15:0] mem_arr [0:65535];
  logic [15:0] mdr = '0;

  always #5 clk = ~clk;

  mem_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_enable(mem_enable), .mem_output_en(mem_output_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .verify_err(verify_err), .clear_err(clear_err)
  );

  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_read_write)
        mdr <= bad_read ? 16'h1234 : mem_arr[mem_address];
      else
        mem_arr[mem_address] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_enable && mem_output_en) ? mdr : 16'hzzzz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rd);
    int lat, en_n, oe_n, exp_lat, exp_en, exp_oe;
    logic [15:0] exp_data;
    bit done;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 16'hA5A5; req_wdata = 16'h5A5A; req_write = ~wr;
    lat = 1; en_n = 0; oe_n = 0; done = 0;
    while (!done && lat <= 10) begin
      if (rsp_valid) done = 1;
      else begin
        if (mem_enable) begin
          en_n++;
          check("mem_address", mem_address, addr);
        end
        if (mem_output_en) oe_n++;
        if (lat == 1) begin
          check("first_read_write", mem_read_write, !wr);
          if (wr) check("mem_wdata", mem_wdata, wdata);
        end
        lat++;
        @(negedge clk);
      end
    end
    if (wr) begin
`ifdef MEM_MASTER_WRITE_VERIFY_EN
      exp_lat = 4; exp_en = 3; exp_oe = 2; exp_data = wdata;
`else
      exp_lat = 2; exp_en = 1; exp_oe = 0; exp_data = last_rdata;
`endif
    end else begin
      exp_lat = 3; exp_en = 2; exp_oe = 2; exp_data = exp_rd;
    end
    check("rsp_seen", done, 1);
    check("latency", lat, exp_lat);
    check("enable_cycles", en_n, exp_en);
    check("output_en_cycles", oe_n, exp_oe);
    check("rsp_write", rsp_write, wr);
    check("rsp_rdata", rsp_rdata, exp_data);
    check("mem_enable_in_resp", mem_enable, 0);
    last_rdata = exp_data;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int seen;
    bit done;
    logic [15:0] exp_err;
    for (int i = 0; i < 65536; i++) mem_arr[i] = '0;

    vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[4] = '{1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{1'b1, 16'h0007, 16'h00A5, 16'h0000};

    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_enable", mem_enable, 0);
    check("rst_mem_read_write", mem_read_write, 0);
    check("rst_mem_output_en", mem_output_en, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_write", rsp_write, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_verify_err", verify_err, 0);
    reset = 1'b1;

    // reset while in RD_ADDR
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0003;
    @(negedge clk);
    req_valid = 1'b0;
    check("midrd_in_rd_addr", mem_enable && mem_output_en, 1);
    reset = 1'b0;
    @(negedge clk);
    check("midrd_idle_ready", req_ready, 1);
    check("midrd_enable_off", mem_enable, 0);
    check("midrd_no_rsp", rsp_valid, 0);
    reset = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("midrd_no_rsp_after", seen, 0);

    for (int i = 0; i < 6; i++)
      do_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

    // second request held during a read, address changes mid-operation
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
    @(negedge clk);
    req_addr = 16'h0020;
    check("b2b_ready_rd_addr", req_ready, 0);
    check("b2b_addr_rd_addr", mem_address, 16'h0010);
    @(negedge clk);
    check("b2b_ready_rd_data", req_ready, 0);
    check("b2b_addr_rd_data", mem_address, 16'h0010);
    @(negedge clk);
    check("b2b_rsp_valid", rsp_valid, 1);
    check("b2b_rsp_rdata", rsp_rdata, 16'hBEEF);
    check("b2b_ready_resp", req_ready, 0);
    @(negedge clk);
    check("b2b_idle_ready", req_ready, 1);
    check("b2b_idle_enable", mem_enable, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_enable", mem_enable, 1);
    check("b2b_second_addr", mem_address, 16'h0020);
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      if (rsp_valid) done = 1; else @(negedge clk);
    end
    check("b2b_second_rsp", done, 1);
    check("b2b_second_rdata", rsp_rdata, 16'h0000);

    // corrupted read-back after a write
    bad_read = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_wdata = 16'h5678;
    @(negedge clk);
    req_valid = 1'b0;
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      if (rsp_valid) done = 1; else @(negedge clk);
    end
    check("vfy_rsp_seen", done, 1);
`ifdef MEM_MASTER_WRITE_VERIFY_EN
    exp_err = 16'h0001;
    check("vfy_rsp_rdata", rsp_rdata, 16'h1234);
`else
    exp_err = 16'h0000;
    check("vfy_rsp_rdata", rsp_rdata, 16'h0000);
`endif
    check("vfy_err_set", verify_err, exp_err);
    repeat (3) @(negedge clk);
    check("vfy_err_sticky", verify_err, exp_err);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("vfy_err_cleared", verify_err, 0);
    bad_read = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
